// File: rtl/input_debounce_pkg.sv
// Shared types and defaults for the board input conditioning block:
// debounce FSM states, default timing and the request handshake update rule.
package input_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO,
    ST_RISE,
    ST_HI,
    ST_FALL
  } db_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int CNT_W_DEFAULT           = 5;

  // A pending request only yields to its ack; a press while pending is lost.
  function automatic logic next_req(input logic req, input logic ack, input logic press);
    logic nxt;
    nxt = req;
    if (req && ack) begin
      nxt = 1'b0;
    end else if (!req && press) begin
      nxt = 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One raw pin: 2-flop synchronizer, four-state debounce FSM with a stability
// counter, and a one-cycle pulse on the first cycle the clean level goes high.
module debounce_cell
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            s1;
  logic            s2;
  db_state_t       state;
  db_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic            stb;
  logic            stb_nxt;
  logic            rise_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_LO;
      cnt        <= '0;
      stb        <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      stb        <= stb_nxt;
      rise_pulse <= rise_nxt;
    end
  end

  // The first differing sample counts as 1, so the level flips on the
  // DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stb_nxt   = stb;
    rise_nxt  = 1'b0;
    unique case (state)
      ST_LO: begin
        if (s2) begin
          state_nxt = ST_RISE;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_RISE: begin
        if (!s2) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
          stb_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s2) begin
          state_nxt = ST_FALL;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_FALL: begin
        if (s2) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
          stb_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_LO;
        cnt_nxt   = '0;
        stb_nxt   = 1'b0;
      end
    endcase
  end

  assign level_out = stb;

endmodule

// File: rtl/input_debounce_ctrl.sv
// Board input conditioning: debounced block-select switches and held write/read
// requests. Optional macro SEL_LOCK_WHILE_REQ_EN freezes each select while its request is pending.
module input_debounce_ctrl
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic switch0,
  input  logic switch1,
  input  logic btn_write,
  input  logic btn_read,
  input  logic wr_ack,
  input  logic rd_ack,
  output logic wr_sel,
  output logic rd_sel,
  output logic wr_req,
  output logic rd_req
);

  logic       wr_lvl;
  logic       rd_lvl;
  logic       wr_press;
  logic       rd_press;
  logic [1:0] sel_rise_unused;
  logic [1:0] btn_level_unused;

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw0 (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (switch0),
    .level_out  (wr_lvl),
    .rise_pulse (sel_rise_unused[0])
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw1 (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (switch1),
    .level_out  (rd_lvl),
    .rise_pulse (sel_rise_unused[1])
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn_wr (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (btn_write),
    .level_out  (btn_level_unused[0]),
    .rise_pulse (wr_press)
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn_rd (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (btn_read),
    .level_out  (btn_level_unused[1]),
    .rise_pulse (rd_press)
  );

  // An ack landing with a new press clears the old request and drops the press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_req <= 1'b0;
      rd_req <= 1'b0;
    end else begin
      wr_req <= next_req(wr_req, wr_ack, wr_press);
      rd_req <= next_req(rd_req, rd_ack, rd_press);
    end
  end

`ifdef SEL_LOCK_WHILE_REQ_EN
  logic wr_sel_hold;
  logic rd_sel_hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_sel_hold <= 1'b0;
      rd_sel_hold <= 1'b0;
    end else begin
      if (!wr_req) wr_sel_hold <= wr_lvl;
      if (!rd_req) rd_sel_hold <= rd_lvl;
    end
  end

  assign wr_sel = wr_req ? wr_sel_hold : wr_lvl;
  assign rd_sel = rd_req ? rd_sel_hold : rd_lvl;
`else
  assign wr_sel = wr_lvl;
  assign rd_sel = rd_lvl;
`endif

endmodule

// File: tb/tb_input_debounce_ctrl.sv
// Directed bench for input_debounce_ctrl with DEBOUNCE_CYCLES=4: reset, glitch,
// bounce, handshake, ack/press collision, select lock and reset mid-operation.
module tb_input_debounce_ctrl;

  logic clock;
  logic reset;
  logic switch0;
  logic switch1;
  logic btn_write;
  logic btn_read;
  logic wr_ack;
  logic rd_ack;
  logic wr_sel;
  logic rd_sel;
  logic wr_req;
  logic rd_req;

  int test_count = 0;
  int fail_count = 0;

  input_debounce_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .switch0   (switch0),
    .switch1   (switch1),
    .btn_write (btn_write),
    .btn_read  (btn_read),
    .wr_ack    (wr_ack),
    .rd_ack    (rd_ack),
    .wr_sel    (wr_sel),
    .rd_sel    (rd_sel),
    .wr_req    (wr_req),
    .rd_req    (rd_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic sw0, input logic sw1, input logic bw, input logic br);
    switch0   = sw0;
    switch1   = sw1;
    btn_write = bw;
    btn_read  = br;
  endtask

  task automatic pulseWrAck();
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
  endtask

  task automatic pulseRdAck();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    // Reset held with every raw input high
    tick(3);
    checkOutput("rst_wr_sel", wr_sel, 1'b0);
    checkOutput("rst_rd_sel", rd_sel, 1'b0);
    checkOutput("rst_wr_req", wr_req, 1'b0);
    checkOutput("rst_rd_req", rd_req, 1'b0);

    reset = 1'b1;
    tick(5);
    checkOutput("rel_wr_sel_5", wr_sel, 1'b0);
    tick(1);
    checkOutput("rel_wr_sel_6", wr_sel, 1'b1);
    checkOutput("rel_rd_sel_6", rd_sel, 1'b1);
    checkOutput("rel_wr_req_6", wr_req, 1'b0);
    tick(1);
    checkOutput("rel_wr_req_7", wr_req, 1'b1);
    checkOutput("rel_rd_req_7", rd_req, 1'b1);

    wr_ack = 1'b1;
    rd_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    checkOutput("ack_wr_req", wr_req, 1'b0);
    checkOutput("ack_rd_req", rd_req, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(10);
    checkOutput("release_wr_sel", wr_sel, 1'b0);
    checkOutput("release_rd_sel", rd_sel, 1'b0);
    checkOutput("release_wr_req", wr_req, 1'b0);

    // Glitch: three samples high is one short
    switch0 = 1'b1;
    tick(3);
    switch0 = 1'b0;
    tick(10);
    checkOutput("glitch_wr_sel", wr_sel, 1'b0);

    switch0 = 1'b1;
    tick(5);
    checkOutput("clean_wr_sel_5", wr_sel, 1'b0);
    tick(1);
    checkOutput("clean_wr_sel_6", wr_sel, 1'b1);

    // Bounce on the write button, final rising edge then held
    btn_write = 1'b1; tick(1);
    btn_write = 1'b0; tick(1);
    btn_write = 1'b1; tick(1);
    btn_write = 1'b0; tick(1);
    btn_write = 1'b1;
    tick(6);
    checkOutput("bounce_wr_req_6", wr_req, 1'b0);
    tick(1);
    checkOutput("bounce_wr_req_7", wr_req, 1'b1);

    // Request held without ack, then acked
    tick(20);
    checkOutput("hold_wr_req", wr_req, 1'b1);
    pulseWrAck();
    checkOutput("hs_ack_wr_req", wr_req, 1'b0);

    btn_write = 1'b0;
    tick(10);
    checkOutput("hs_release_wr_req", wr_req, 1'b0);
    btn_write = 1'b1;
    tick(7);
    checkOutput("hs_press2_wr_req", wr_req, 1'b1);
    btn_write = 1'b0;
    tick(8);
    checkOutput("hs_rel_keeps_req", wr_req, 1'b1);
    btn_write = 1'b1;
    tick(10);
    checkOutput("hs_pending_press", wr_req, 1'b1);
    pulseWrAck();
    checkOutput("hs_ack2_wr_req", wr_req, 1'b0);
    tick(10);
    checkOutput("hs_no_queued_req", wr_req, 1'b0);
    btn_write = 1'b0;
    tick(8);

    // Read press coinciding with the ack of the prior request
    btn_read = 1'b1;
    tick(7);
    checkOutput("col_rd_req_first", rd_req, 1'b1);
    btn_read = 1'b0;
    tick(8);
    btn_read = 1'b1;
    tick(6);
    pulseRdAck();
    checkOutput("col_rd_req_after", rd_req, 1'b0);
    tick(10);
    checkOutput("col_press_dropped", rd_req, 1'b0);
    checkOutput("col_wr_req_indep", wr_req, 1'b0);

    // Select behaviour while a write request is pending
    switch0 = 1'b0;
    tick(8);
    checkOutput("lock_pre_wr_sel", wr_sel, 1'b0);
    btn_write = 1'b1;
    tick(7);
    checkOutput("lock_wr_req", wr_req, 1'b1);
    switch0 = 1'b1;
    tick(6);
`ifdef SEL_LOCK_WHILE_REQ_EN
    checkOutput("lock_wr_sel_6", wr_sel, 1'b0);
    tick(4);
    checkOutput("lock_wr_sel_10", wr_sel, 1'b0);
`else
    checkOutput("nolock_wr_sel_6", wr_sel, 1'b1);
    tick(4);
    checkOutput("nolock_wr_sel_10", wr_sel, 1'b1);
`endif
    pulseWrAck();
    checkOutput("lock_ack_wr_req", wr_req, 1'b0);
    checkOutput("lock_ack_wr_sel", wr_sel, 1'b1);

    // Async reset with the write button still held
    reset = 1'b0;
    #1;
    checkOutput("async_rst_wr_sel", wr_sel, 1'b0);
    checkOutput("async_rst_rd_req", rd_req, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(6);
    checkOutput("rerun_wr_req_6", wr_req, 1'b0);
    tick(1);
    checkOutput("rerun_wr_req_7", wr_req, 1'b1);
    checkOutput("rerun_rd_req_7", rd_req, 1'b1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
